ram_sweep_ctrl: RTL and testbench

Sequencer for the paired dual-port RAM compute datapath. It sweeps an address range and issues one read per cycle on the RAM read ports. One cycle later it writes the combinational adder/subtractor result back to the same address through the RAM write ports. It replaces the hand-coded per-experiment FSMs with a reusable controller that has a start/done handshake, hold/abort control, and a selectable write mask.

---
 rtl/ram_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_ram_sweep_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_sweep_ctrl
//  Purpose  : Address sweep sequencer for the paired dual-port RAM compute
//             datapath. Issues one read per cycle over [base..last] (modulo
//             2^ADDR_W) and writes the adder/subtractor result back to the
//             same address one cycle later. Start/done handshake, hold
//             freeze, abort and a per-RAM write mask.
//  Revision : 1.0  initial release
// ============================================================================
module ram_sweep_ctrl #(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              CLOCK_50_I,
  input  logic              resetn,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  input  logic [1:0]        wr_mask_i,
  input  logic              hold_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [1:0]        wren_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [ADDR_W:0]   wr_count_o
);

  // The write-back pipeline assumes q is valid exactly one cycle after the
  // read address is registered; any other latency would misalign writes.
  generate
    if (RD_LAT != 1) begin : g_rd_lat_check
      $error("ram_sweep_ctrl: only RD_LAT == 1 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LEAD_IN    = 2'd1,
    S_RUN        = 2'd2,
    S_LAST_WRITE = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_last, w_last_nxt;
  logic [1:0]          r_mask, w_mask_nxt;
  logic [ADDR_W-1:0]   r_rd_addr, w_rd_addr_nxt;
  logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic                r_wr_pend, w_wr_pend_nxt;
  logic                r_done, w_done_nxt;
  logic                r_aborted, w_aborted_nxt;
  logic [ADDR_W:0]     r_wr_count, w_wr_count_nxt;

  localparam logic [ADDR_W-1:0] C_ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   C_COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // State register and all datapath registers, synchronous active-low reset
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_last     <= '0;
      r_mask     <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_pend  <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_mask     <= w_mask_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_pend  <= w_wr_pend_nxt;
      r_done     <= w_done_nxt;
      r_aborted  <= w_aborted_nxt;
      r_wr_count <= w_wr_count_nxt;
    end
  end

  // Next-state and sequencing: abort beats hold, hold freezes everything
  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_mask_nxt     = r_mask;
    w_rd_addr_nxt  = r_rd_addr;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_pend_nxt  = r_wr_pend;
    w_done_nxt     = 1'b0;
    w_aborted_nxt  = 1'b0;
    // A presented write slot counts unless hold suppressed it, mask ignored
    w_wr_count_nxt = (r_wr_pend && !hold_i) ? (r_wr_count + C_COUNT_ONE) : r_wr_count;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_last_nxt     = last_addr_i;
          w_mask_nxt     = wr_mask_i;
          w_rd_addr_nxt  = base_addr_i;
          w_wr_count_nxt = '0;
          w_state_nxt    = S_LEAD_IN;
        end
      end
      default: begin
        if (abort_i) begin
          w_state_nxt   = S_IDLE;
          w_wr_pend_nxt = 1'b0;
          w_aborted_nxt = 1'b1;
        end else if (!hold_i) begin
          if (r_state == S_LAST_WRITE) begin
            w_wr_pend_nxt = 1'b0;
            w_done_nxt    = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            // Lead-in and run share the same per-address step
            w_wr_addr_nxt = r_rd_addr;
            w_wr_pend_nxt = 1'b1;
            if (r_rd_addr == r_last) begin
              w_state_nxt = S_LAST_WRITE;
            end else begin
              w_rd_addr_nxt = r_rd_addr + C_ADDR_ONE;
              w_state_nxt   = S_RUN;
            end
          end
        end
      end
    endcase
  end

  // Hold gates the write enables in the same cycle so no RAM write is lost
  assign wren_o     = r_wr_pend ? (r_mask & ~{2{hold_i}}) : 2'b00;
  assign rd_addr_o  = r_rd_addr;
  assign wr_addr_o  = r_wr_addr;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = r_done;
  assign aborted_o  = r_aborted;
  assign wr_count_o = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_ram_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_sweep_ctrl
//  Purpose  : Self-checking bench for ram_sweep_ctrl. Each sweep's expected
//             write schedule is derived from the sweep length, hold window and
//             abort point with plain arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_sweep_ctrl;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              CLOCK_50_I = 1'b0;
  logic              resetn;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W-1:0] last_addr_i;
  logic [1:0]        wr_mask_i;
  logic              hold_i;
  logic              abort_i;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [1:0]        wren_o;
  logic              busy_o;
  logic              done_o;
  logic              aborted_o;
  logic [ADDR_W:0]   wr_count_o;

  int tests = 0;
  int fails = 0;

  // 50 MHz clock
  always #10 CLOCK_50_I = ~CLOCK_50_I;

  ram_sweep_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .last_addr_i(last_addr_i),
    .wr_mask_i  (wr_mask_i),
    .hold_i     (hold_i),
    .abort_i    (abort_i),
    .rd_addr_o  (rd_addr_o),
    .wr_addr_o  (wr_addr_o),
    .wren_o     (wren_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .aborted_o  (aborted_o),
    .wr_count_o (wr_count_o)
  );

  // Cycle (counted in rising edges after the start edge) at which write k is
  // presented: two cycles of lead-in, then one per address, pushed back by
  // the hold window if it precedes that write.
  function automatic int wcyc(int k, int hold_at, int hold_len);
    return 2 + k + ((hold_at >= 0 && k >= hold_at) ? hold_len : 0);
  endfunction

  // One sweep: hold_at = write index at which hold begins (-1 none),
  // abort_at = write index presented in the abort cycle (-1 none),
  // stray_at = cycle at which an ignored start is pulsed (-1 none).
  task automatic run_sweep(input string name, input logic [ADDR_W-1:0] base,
                           input logic [ADDR_W-1:0] last, input logic [1:0] mask,
                           input int hold_at, input int hold_len,
                           input int abort_at, input int stray_at);
    int n, nw, last_busy, kexp, werr, berr, derr, aerr, ferr;
    logic [ADDR_W-1:0] ea, bad_addr, prev_rd, prev_wr;
    logic [ADDR_W:0]   prev_cnt;
    int bad_cyc;
    n  = ((int'(last) - int'(base) + DEPTH) % DEPTH) + 1;
    nw = (abort_at >= 0) ? abort_at + 1 : n;
    last_busy = wcyc(nw - 1, hold_at, hold_len);
    werr = 0; berr = 0; derr = 0; aerr = 0; ferr = 0; kexp = 0;
    bad_cyc = -1; bad_addr = '0;
    prev_rd = '0; prev_wr = '0; prev_cnt = '0;

    @(negedge CLOCK_50_I);
    start_i = 1'b1; base_addr_i = base; last_addr_i = last; wr_mask_i = mask;
    hold_i = 1'b0; abort_i = 1'b0;
    for (int c = 1; c <= last_busy + 3; c++) begin
      @(negedge CLOCK_50_I);
      start_i = (c == stray_at);
      if (c == stray_at) begin
        base_addr_i = ADDR_W'($urandom);
        last_addr_i = ADDR_W'($urandom);
        wr_mask_i   = 2'($urandom);
      end
      hold_i  = (hold_at >= 0 && c >= 2 + hold_at && c < 2 + hold_at + hold_len);
      abort_i = (abort_at >= 0 && c == last_busy);
      #1;
      if (kexp < nw && c == wcyc(kexp, hold_at, hold_len)) begin
        ea = base + ADDR_W'(kexp);
        if (wr_addr_o !== ea || wren_o !== mask) begin
          werr++;
          if (bad_cyc < 0) begin bad_cyc = c; bad_addr = wr_addr_o; end
        end
        kexp++;
      end else if (wren_o !== 2'b00) begin
        werr++;
        if (bad_cyc < 0) begin bad_cyc = c; bad_addr = wr_addr_o; end
      end
      if (busy_o !== (c <= last_busy)) berr++;
      if (done_o !== (abort_at < 0 && c == last_busy + 1)) derr++;
      if (aborted_o !== (abort_at >= 0 && c == last_busy + 1)) aerr++;
      if (hold_at >= 0 && c > 2 + hold_at && c <= 2 + hold_at + hold_len) begin
        if (rd_addr_o !== prev_rd || wr_addr_o !== prev_wr || wr_count_o !== prev_cnt)
          ferr++;
      end
      prev_rd = rd_addr_o; prev_wr = wr_addr_o; prev_cnt = wr_count_o;
    end
    start_i = 1'b0; hold_i = 1'b0; abort_i = 1'b0;

    tests++;
    if (werr != 0) begin
      fails++;
      $display("FAIL %s writes: %0d bad cycles, first at cycle %0d wr_addr=%0d, required base=%0d n=%0d mask=%b",
               name, werr, bad_cyc, bad_addr, base, nw, mask);
    end
    tests++;
    if (berr != 0) begin
      fails++;
      $display("FAIL %s busy: %0d bad cycles, required high for cycles 1..%0d", name, berr, last_busy);
    end
    tests++;
    if (derr != 0) begin
      fails++;
      $display("FAIL %s done: %0d bad cycles, required pulse %s", name, derr,
               (abort_at < 0) ? "once after last write" : "never");
    end
    tests++;
    if (aerr != 0) begin
      fails++;
      $display("FAIL %s aborted: %0d bad cycles, required pulse %s", name, aerr,
               (abort_at >= 0) ? "once after abort" : "never");
    end
    if (hold_at >= 0) begin
      tests++;
      if (ferr != 0) begin
        fails++;
        $display("FAIL %s hold_freeze: %0d cycles changed during hold, required 0", name, ferr);
      end
    end
    tests++;
    if (wr_count_o !== (ADDR_W+1)'(nw)) begin
      fails++;
      $display("FAIL %s wr_count: got %0d, required %0d", name, wr_count_o, nw);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start_i = 1'b0; hold_i = 1'b0; abort_i = 1'b0;
    base_addr_i = '0; last_addr_i = '0; wr_mask_i = '0;
    repeat (3) @(negedge CLOCK_50_I);
    #1;
    tests++;
    if ({rd_addr_o, wr_addr_o} !== '0) begin
      fails++;
      $display("FAIL reset_addr: rd=%0d wr=%0d, required 0 0", rd_addr_o, wr_addr_o);
    end
    tests++;
    if ({wren_o, busy_o, done_o, aborted_o} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: wren=%b busy=%b done=%b aborted=%b, required all 0",
               wren_o, busy_o, done_o, aborted_o);
    end
    tests++;
    if (wr_count_o !== '0) begin
      fails++;
      $display("FAIL reset_count: got %0d, required 0", wr_count_o);
    end
    resetn = 1'b1;
  endtask

  task automatic test_full_sweep();
    run_sweep("full", 9'd0, 9'd511, 2'b11, -1, 0, -1, -1);
  endtask

  task automatic test_single();
    run_sweep("single", 9'd37, 9'd37, 2'b01, -1, 0, -1, -1);
  endtask

  task automatic test_wrap();
    run_sweep("wrap", 9'd510, 9'd1, 2'b10, -1, 0, -1, -1);
  endtask

  task automatic test_hold();
    run_sweep("hold", 9'd0, 9'd9, 2'b11, 4, 3, -1, -1);
  endtask

  task automatic test_abort_restart();
    run_sweep("abort", 9'd0, 9'd20, 2'b11, -1, 0, 5, 4);
    run_sweep("restart", 9'd0, 9'd20, 2'b11, -1, 0, -1, -1);
  endtask

  task automatic test_reset_mid();
    int perr;
    @(negedge CLOCK_50_I);
    start_i = 1'b1; base_addr_i = 9'd0; last_addr_i = 9'd300; wr_mask_i = 2'b11;
    for (int c = 1; c < 102; c++) begin
      @(negedge CLOCK_50_I);
      start_i = 1'b0;
    end
    @(negedge CLOCK_50_I);
    #1;
    tests++;
    if (wr_addr_o !== 9'd100 || wren_o !== 2'b11) begin
      fails++;
      $display("FAIL rstmid_pre: wr_addr=%0d wren=%b, required 100 11", wr_addr_o, wren_o);
    end
    resetn = 1'b0;
    @(negedge CLOCK_50_I);
    #1;
    tests++;
    if ({rd_addr_o, wr_addr_o, wren_o, busy_o, done_o, aborted_o, wr_count_o} !== '0) begin
      fails++;
      $display("FAIL rstmid_clear: rd=%0d wr=%0d wren=%b busy=%b done=%b ab=%b cnt=%0d, required all 0",
               rd_addr_o, wr_addr_o, wren_o, busy_o, done_o, aborted_o, wr_count_o);
    end
    resetn = 1'b1;
    perr = 0;
    repeat (5) begin
      @(negedge CLOCK_50_I);
      #1;
      if (done_o !== 1'b0 || aborted_o !== 1'b0 || busy_o !== 1'b0) perr++;
    end
    tests++;
    if (perr != 0) begin
      fails++;
      $display("FAIL rstmid_quiet: %0d cycles with done/aborted/busy, required 0", perr);
    end
    run_sweep("after_reset", 9'd200, 9'd215, 2'b01, -1, 0, -1, -1);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] b, l;
    int n, h, hl, a, s;
    for (int i = 0; i < 8; i++) begin
      b  = ADDR_W'($urandom);
      n  = int'($urandom_range(1, 40));
      l  = b + ADDR_W'(n - 1);
      a  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      h  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      if (a >= 0 && h > a) h = -1;
      hl = int'($urandom_range(1, 4));
      s  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 2)) : -1;
      run_sweep($sformatf("rand%0d", i), b, l, 2'($urandom_range(1, 3)), h, hl, a, s);
    end
  endtask

  task automatic test_back_to_back();
    run_sweep("b2b_a", 9'd100, 9'd103, 2'b11, -1, 0, -1, -1);
    run_sweep("b2b_b", 9'd511, 9'd511, 2'b10, 0, 2, -1, -1);
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_single();
    test_wrap();
    test_hold();
    test_abort_restart();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
